// File: rtl/uart_pkg.sv
`default_nettype none
//==============================================================================
// Module   : uart_pkg
// Purpose  : Types and helpers shared by the host-link UART (uart_rx / uart_tx).
//            - state_t  : frame state encoding (explicit 3-bit width)
//            - PAR_*    : parity mode encoding for the PARITY parameter
//            - parity_bit() : expected parity bit for a data word
// Ports    : none (package)
// Revision : 1.0 - initial release
//==============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY_S = 3'd3,
        STOP     = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Zero-extension to 32 bits leaves the XOR reduction unchanged, so one
    // function serves any data width up to 32.
    function automatic logic parity_bit(input logic [31:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
//==============================================================================
// Module   : uart_baud_gen
// Purpose  : Oversample clock-enable generator for the host-link UART.
//            USE_NCO=0 : integer divider, period max(CLK_HZ/(BAUD*OVERSAMPLE),1)
//            USE_NCO=1 : phase accumulator, enable = accumulator carry-out
// Ports    : i_clk    - system clock
//            i_rst_n  - synchronous active-low reset
//            o_ce_ovr - one-cycle enable at BAUD*OVERSAMPLE rate
// Revision : 1.0 - initial release
//==============================================================================
module uart_baud_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int USE_NCO    = 0,
    parameter int ACCW       = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_ce_ovr
);

    generate
        if (USE_NCO != 0) begin : g_nco
            // Rounded increment: ((BAUD*OVERSAMPLE) << ACCW) / CLK_HZ
            localparam logic [63:0] c_num   = (64'(BAUD) * 64'(OVERSAMPLE)) << ACCW;
            localparam logic [63:0] c_inc64 = (c_num + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
            localparam logic [ACCW-1:0] c_inc = c_inc64[ACCW-1:0];

            logic [ACCW-1:0] r_acc;
            logic [ACCW:0]   w_sum;

            assign w_sum    = {1'b0, r_acc} + {1'b0, c_inc};
            assign o_ce_ovr = w_sum[ACCW];

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_acc <= '0;
                end else begin
                    r_acc <= w_sum[ACCW-1:0];
                end
            end
        end else begin : g_div
            localparam int c_raw    = CLK_HZ / (BAUD * OVERSAMPLE);
            localparam int c_period = (c_raw < 1) ? 1 : c_raw;
            localparam int c_cnt_w  = (c_period > 1) ? $clog2(c_period) : 1;
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_period - 1);

            logic [c_cnt_w-1:0] r_cnt;
            logic               w_wrap;

            assign w_wrap   = (r_cnt == c_last);
            assign o_ce_ovr = w_wrap;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (w_wrap) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
//==============================================================================
// Module   : uart_rx
// Purpose  : UART receiver. Idle-high serial line -> parallel word with
//            valid/ready handshake, parity/framing flags and overrun pulse.
// Ports    : i_clk        - system clock
//            i_rst_n      - synchronous active-low reset
//            i_rx         - asynchronous serial input, idle high
//            o_data       - received word (DATA_BITS)
//            o_valid      - o_data and error flags valid
//            i_ready      - consumer accepts word when o_valid & i_ready
//            o_parity_err - parity mismatch, qualified by o_valid
//            o_frame_err  - a stop bit was sampled 0, qualified by o_valid
//            o_overrun    - one-cycle pulse: word dropped because consumer stalled
//            o_busy       - receiver not in IDLE
// Options  : UART_RX_MAJORITY_EN - 2-of-3 vote over phases MID-2..MID,
//            decision at MID; otherwise a single sample at MID-1.
// Revision : 1.0 - initial release
//==============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int USE_NCO    = 0,
    parameter int ACCW       = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int c_mid  = OVERSAMPLE / 2;
    localparam int c_ph_w = $clog2(OVERSAMPLE);
    localparam int c_bi_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int c_dec  = c_mid;
`else
    localparam int c_dec  = c_mid - 1;
`endif
    localparam logic [c_ph_w-1:0] c_dec_ph    = c_ph_w'(c_dec);
    localparam logic [c_ph_w-1:0] c_last_ph   = c_ph_w'(OVERSAMPLE - 1);
    localparam logic [c_bi_w-1:0] c_bi_last   = c_bi_w'(DATA_BITS - 1);
    localparam logic              c_stop_last = 1'(STOP_BITS - 1);

    logic                 w_ce;
    logic [1:0]           r_sync;
    logic                 w_rx_s;
    logic                 w_bit;

    state_t               r_state, w_state_nxt;
    logic [c_ph_w-1:0]    r_phase, w_phase_nxt;
    logic [c_bi_w-1:0]    r_bit_idx, w_bit_idx_nxt;
    logic                 r_stop_idx, w_stop_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_shifted;
    logic                 r_perr_acc, w_perr_acc_nxt;
    logic                 r_ferr_acc, w_ferr_acc_nxt;
    logic                 r_armed, w_armed_nxt;
    logic                 w_complete;
    logic                 w_done_ferr;
    logic                 w_dec, w_last;

    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_perr, w_perr_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_overrun, w_overrun_nxt;

    uart_baud_gen #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .USE_NCO    (USE_NCO),
        .ACCW       (ACCW)
    ) u_baud (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .o_ce_ovr (w_ce)
    );

    // Two-flop synchronizer; resets to the idle level so reset never looks
    // like a start edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end
    assign w_rx_s = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_ph_w-1:0] c_pre2_ph = c_ph_w'(c_mid - 2);
    localparam logic [c_ph_w-1:0] c_pre1_ph = c_ph_w'(c_mid - 1);
    logic r_samp_a, r_samp_b;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else if (w_ce && (r_state != IDLE)) begin
            if (r_phase == c_pre2_ph) r_samp_a <= w_rx_s;
            if (r_phase == c_pre1_ph) r_samp_b <= w_rx_s;
        end
    end
    // Third vote is the live sample at the decision phase.
    assign w_bit = (r_samp_a & r_samp_b) | (r_samp_a & w_rx_s) | (r_samp_b & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    assign w_dec  = (r_phase == c_dec_ph);
    assign w_last = (r_phase == c_last_ph);

    // Frame sequencing: next state and datapath accumulators.
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_shift_nxt    = r_shift;
        w_perr_acc_nxt = r_perr_acc;
        w_ferr_acc_nxt = r_ferr_acc;
        w_armed_nxt    = r_armed;
        w_complete     = 1'b0;
        w_done_ferr    = r_ferr_acc;
        w_shifted      = r_shift >> 1;
        w_shifted[DATA_BITS-1] = w_bit;

        case (r_state)
            IDLE: begin
                // After a break the line must return high before the next
                // falling edge counts as a start bit.
                if (w_rx_s) w_armed_nxt = 1'b1;
                if (w_ce && r_armed && !w_rx_s) begin
                    w_state_nxt    = START;
                    w_phase_nxt    = '0;
                    w_perr_acc_nxt = 1'b0;
                    w_ferr_acc_nxt = 1'b0;
                end
            end
            START: begin
                if (w_ce) begin
                    if (w_dec && w_bit) begin
                        w_state_nxt = IDLE;
                        w_phase_nxt = '0;
                    end else if (w_last) begin
                        w_state_nxt   = DATA;
                        w_phase_nxt   = '0;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase + c_ph_w'(1);
                    end
                end
            end
            DATA: begin
                if (w_ce) begin
                    if (w_dec) w_shift_nxt = w_shifted;
                    if (w_last) begin
                        w_phase_nxt = '0;
                        if (r_bit_idx == c_bi_last) begin
                            w_stop_idx_nxt = 1'b0;
                            if (PARITY != PAR_NONE) w_state_nxt = PARITY_S;
                            else                    w_state_nxt = STOP;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + c_bi_w'(1);
                        end
                    end else begin
                        w_phase_nxt = r_phase + c_ph_w'(1);
                    end
                end
            end
            PARITY_S: begin
                if (w_ce) begin
                    if (w_dec) w_perr_acc_nxt = (w_bit != parity_bit(32'(r_shift), PARITY));
                    if (w_last) begin
                        w_state_nxt    = STOP;
                        w_phase_nxt    = '0;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_phase_nxt = r_phase + c_ph_w'(1);
                    end
                end
            end
            STOP: begin
                if (w_ce) begin
                    if (w_dec && (r_stop_idx == c_stop_last)) begin
                        // Finish at the mid-bit of the last stop bit so the
                        // next start edge can be caught without slip.
                        w_complete     = 1'b1;
                        w_done_ferr    = r_ferr_acc | ~w_bit;
                        w_ferr_acc_nxt = w_done_ferr;
                        w_state_nxt    = IDLE;
                        w_phase_nxt    = '0;
                        w_armed_nxt    = w_bit;
                    end else begin
                        if (w_dec && !w_bit) w_ferr_acc_nxt = 1'b1;
                        if (w_last) begin
                            w_stop_idx_nxt = 1'b1;
                            w_phase_nxt    = '0;
                        end else begin
                            w_phase_nxt = r_phase + c_ph_w'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // Output register: a new word is only accepted into the output slot when
    // it is empty or being emptied this very cycle.
    always_comb begin
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_perr_nxt    = r_perr;
        w_ferr_nxt    = r_ferr;
        w_overrun_nxt = 1'b0;
        if (w_complete) begin
            if (!r_valid || i_ready) begin
                w_data_nxt  = r_shift;
                w_perr_nxt  = r_perr_acc;
                w_ferr_nxt  = w_done_ferr;
                w_valid_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end else if (r_valid && i_ready) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_armed    <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_perr_acc <= w_perr_acc_nxt;
            r_ferr_acc <= w_ferr_acc_nxt;
            r_armed    <= w_armed_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;
    assign o_overrun    = r_overrun;
    assign o_busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Three instances:
//            u_dut - defaults (8N1, 115200 @ 50 MHz, divider)
//            u_par - even parity, 781250 baud (exact divider of 4)
//            u_nco - NCO tick, two stop bits, 781250 baud
// Revision : 1.0 - initial release
//==============================================================================
module tb_uart_rx;

    localparam int MAIN_BC = 434;   // 50 MHz / 115200
    localparam int FAST_BC = 64;    // 50 MHz / 781250

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stopv;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n;
    logic       rx0, rx1, rx2;
    logic       rdy0, rdy1, rdy2;
    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       ov0, ov1, ov2;
    logic       b0, b1, b2;

    uart_rx u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx0), .o_data(d0), .o_valid(v0),
        .i_ready(rdy0), .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0), .o_busy(b0)
    );

    uart_rx #(.BAUD(781_250), .PARITY(1)) u_par (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1), .o_data(d1), .o_valid(v1),
        .i_ready(rdy1), .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1), .o_busy(b1)
    );

    uart_rx #(.BAUD(781_250), .STOP_BITS(2), .USE_NCO(1)) u_nco (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx2), .o_data(d2), .o_valid(v2),
        .i_ready(rdy2), .o_parity_err(pe2), .o_frame_err(fe2), .o_overrun(ov2), .o_busy(b2)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t q0[$], q1[$], q2[$];
    int   ovc0 = 0, ovc1 = 0, ovc2 = 0, vc0 = 0;

    // Handshake monitors: record each accepted word, count overrun pulses.
    always @(negedge clk) begin
        if (v0 && rdy0) q0.push_back({d0, pe0, fe0});
        if (v1 && rdy1) q1.push_back({d1, pe1, fe1});
        if (v2 && rdy2) q2.push_back({d2, pe2, fe2});
        if (v0)  vc0++;
        if (ov0) ovc0++;
        if (ov1) ovc1++;
        if (ov2) ovc2++;
    end

    initial begin
        repeat (150_000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic clear_mon();
        q0.delete(); q1.delete(); q2.delete();
        ovc0 = 0; ovc1 = 0; ovc2 = 0; vc0 = 0;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stopv, input int nstop);
        int bc;
        bc = (sel == 0) ? MAIN_BC : FAST_BC;
        drive(sel, 1'b0);
        hold(bc);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            hold(bc);
        end
        if (has_par) begin
            drive(sel, pbit);
            hold(bc);
        end
        drive(sel, stopv);
        hold(bc);
        if (nstop == 2) begin
            drive(sel, 1'b1);
            hold(bc);
        end
        drive(sel, 1'b1);
    endtask

    task automatic pop_check(input int sel, input string name, input logic [7:0] d,
                             input logic pe, input logic fe);
        rec_t r;
        int   n;
        case (sel)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        check({name, "_avail"}, 32'(n != 0), 32'd1);
        r = 'x;
        if (n != 0) begin
            case (sel)
                0:       r = q0.pop_front();
                1:       r = q1.pop_front();
                default: r = q2.pop_front();
            endcase
        end
        check({name, "_data"}, 32'(r.d), 32'(d));
        check({name, "_perr"}, 32'(r.pe), 32'(pe));
        check({name, "_ferr"}, 32'(r.fe), 32'(fe));
    endtask

    vec_t vecs[7];

    initial begin
        // Even parity: bit = XOR of data bits.
        vecs[0] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        rst_n = 1'b0;
        hold(5);
        check("rst_data",    32'(d0),  32'd0);
        check("rst_valid",   32'(v0),  32'd0);
        check("rst_perr",    32'(pe0), 32'd0);
        check("rst_ferr",    32'(fe0), 32'd0);
        check("rst_overrun", 32'(ov0), 32'd0);
        check("rst_busy",    32'(b0),  32'd0);
        rst_n = 1'b1;
        hold(10);

        // Plain 8N1 word, consumer always ready.
        clear_mon();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1);
        hold(2 * MAIN_BC);
        check("a5_count", 32'(q0.size()), 32'd1);
        check("a5_valid_cycles", 32'(vc0), 32'd1);
        pop_check(0, "a5", 8'hA5, 1'b0, 1'b0);

        // Bad stop bit still delivers the word.
        clear_mon();
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 1);
        hold(2 * MAIN_BC);
        check("badstop_count", 32'(q0.size()), 32'd1);
        pop_check(0, "badstop", 8'h3C, 1'b0, 1'b1);

        // Break: 20 bit-times low -> one zero word, then wait for line high.
        clear_mon();
        drive(0, 1'b0);
        hold(20 * MAIN_BC);
        check("break_count_low", 32'(q0.size()), 32'd1);
        check("break_busy_low", 32'(b0), 32'd0);
        drive(0, 1'b1);
        hold(2 * MAIN_BC);
        check("break_count_high", 32'(q0.size()), 32'd1);
        pop_check(0, "break", 8'h00, 1'b0, 1'b1);

        // Overrun: consumer stalled for two words.
        clear_mon();
        rdy0 = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1);
        hold(MAIN_BC);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1, 1);
        hold(2 * MAIN_BC);
        check("ovr_pulses", 32'(ovc0), 32'd1);
        check("ovr_valid", 32'(v0), 32'd1);
        check("ovr_data_kept", 32'(d0), 32'h11);

        // Ready rises on the exact completion cycle: new word loads, no overrun.
        fork
            send_frame(0, 8'h22, 0, 1'b0, 1'b1, 1);
            begin
                int n;
                n = 0;
                while (u_dut.w_complete !== 1'b1 && n < 20 * MAIN_BC) begin
                    @(negedge clk);
                    n++;
                end
                check("cmpl_seen", 32'(n < 20 * MAIN_BC), 32'd1);
                #1 rdy0 = 1'b1;
                @(negedge clk);
                check("cmpl_data", 32'(d0), 32'h22);
                check("cmpl_valid", 32'(v0), 32'd1);
                check("cmpl_no_ovr", 32'(ov0), 32'd0);
            end
        join
        hold(2 * MAIN_BC);
        check("cmpl_ovr_total", 32'(ovc0), 32'd1);
        check("cmpl_count", 32'(q0.size()), 32'd1);
        pop_check(0, "cmpl", 8'h22, 1'b0, 1'b0);

        // Start glitch of 3 ticks.
        clear_mon();
        drive(0, 1'b0);
        hold(40);
        check("glitch_busy_mid", 32'(b0), 32'd1);
        hold(41);
        drive(0, 1'b1);
        hold(2 * MAIN_BC);
        check("glitch_busy_end", 32'(b0), 32'd0);
        check("glitch_count", 32'(q0.size()), 32'd0);

        // Reset mid-frame while a previous word is pending.
        clear_mon();
        rdy0 = 1'b0;
        send_frame(0, 8'h99, 0, 1'b0, 1'b1, 1);
        hold(MAIN_BC);
        check("pre_rst_valid", 32'(v0), 32'd1);
        check("pre_rst_data", 32'(d0), 32'h99);
        fork
            send_frame(0, 8'h55, 0, 1'b0, 1'b1, 1);
            begin
                hold(5 * MAIN_BC);
                rst_n = 1'b0;
                hold(1);
                check("midrst_valid", 32'(v0), 32'd0);
                check("midrst_data", 32'(d0), 32'd0);
                check("midrst_busy", 32'(b0), 32'd0);
                hold(6 * MAIN_BC);
                rst_n = 1'b1;
            end
        join
        rdy0 = 1'b1;
        clear_mon();
        hold(MAIN_BC);
        send_frame(0, 8'h81, 0, 1'b0, 1'b1, 1);
        hold(2 * MAIN_BC);
        check("post_rst_count", 32'(q0.size()), 32'd1);
        pop_check(0, "post_rst", 8'h81, 1'b0, 1'b0);

        // Even-parity table on u_par.
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            send_frame(1, vecs[i].data, 1, vecs[i].pbit, vecs[i].stopv, 1);
            hold(2 * FAST_BC);
            check($sformatf("par%0d_count", i), 32'(q1.size()), 32'd1);
            pop_check(1, $sformatf("par%0d", i), vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
        end

        // NCO tick, two stop bits, back-to-back frames.
        clear_mon();
        send_frame(2, 8'h00, 0, 1'b0, 1'b1, 2);
        send_frame(2, 8'hFF, 0, 1'b0, 1'b1, 2);
        send_frame(2, 8'h5A, 0, 1'b0, 1'b1, 2);
        hold(2 * FAST_BC);
        check("nco_count", 32'(q2.size()), 32'd3);
        check("nco_no_ovr", 32'(ovc2), 32'd0);
        pop_check(2, "nco0", 8'h00, 1'b0, 1'b0);
        pop_check(2, "nco1", 8'hFF, 1'b0, 1'b0);
        pop_check(2, "nco2", 8'h5A, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. Converts the async serial line (idle=1, start 0, DATA_BITS data LSB-first, optional parity, STOP_BITS stop) into parallel bytes behind a valid/ready output.
It pairs with uart_tx on the host link of Accel v1, so its parameters mirror the transmitter's.
Sampling runs off an oversample clock-enable, from either an integer divider or a fractional NCO.
Each byte carries parity and framing error flags, and an overrun is flagged when the consumer stalls.

Parameters:
DATA_BITS, 8, data bits per frame
CLK_HZ, 50_000_000, system clock frequency
BAUD, 115_200, line rate
OVERSAMPLE, 16, ticks per bit (even, >=8)
PARITY, 0, 0 none / 1 even / 2 odd
STOP_BITS, 1, 1 or 2
USE_NCO, 0, 0 integer divider / 1 NCO
ACCW, 32, NCO accumulator width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_rx  in  1  async serial line, idle high
o_data  out  DATA_BITS  received byte
o_valid  out  1  o_data and error flags valid
i_ready  in  1  consumer accepts byte when o_valid&i_ready
o_parity_err  out  1  parity mismatch on o_data; qualified by o_valid
o_frame_err  out  1  any stop bit sampled 0; qualified by o_valid
o_overrun  out  1  one-cycle pulse: byte completed while o_valid&!i_ready
o_busy  out  1  high while not in IDLE

Behaviour:
- Clock/reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values: o_data=0, o_valid=0, all error flags=0, o_overrun=0, o_busy=0. Synchronizer flops=1. State=IDLE, phase=0, oversample counter/accumulator=0.
- Tick generation: ce_ovr, identical to uart_tx.
  - Divider mode: period max(CLK_HZ/(BAUD*OVERSAMPLE),1).
  - NCO mode: increment round((BAUD*OVERSAMPLE)<<ACCW / CLK_HZ); ce_ovr is the carry-out.
- Input path: i_rx passes a 2-flop synchronizer to give rx_s. Only rx_s is used.
- MID = OVERSAMPLE/2. phase counts 0..OVERSAMPLE-1. It advances only on ce_ovr.
- States: IDLE, START, DATA, PARITY_S, STOP. All transitions occur on ce_ovr cycles.
  - IDLE: rx_s==0 -> START, phase=0.
  - START: sample at phase==MID-1. If the sample is 1, it is a glitch: return to IDLE with no output. At phase==OVERSAMPLE-1 -> DATA with bit_idx=0.
  - DATA: sample at MID-1 and shift right into the MSB (LSB-first). At end of bit, if bit_idx==DATA_BITS-1 go to PARITY_S (PARITY!=0) or STOP; else bit_idx+1.
  - PARITY_S: sample at MID-1. parity_err = sample != (PARITY==1 ? ^data : ~^data).
  - STOP: sample at MID-1. A 0 sets frame_err. If this is the last stop bit, complete the frame on this mid-bit sample and go to IDLE immediately, which allows resync to the next start edge. Otherwise finish the bit period and sample the second stop bit.
- Completion (single cycle):
  - If !o_valid, or o_valid&i_ready on the same cycle: load o_data and error flags, o_valid=1.
  - Otherwise drop the new byte and keep the old one. o_overrun=1 for exactly one cycle.
- Consumption: o_valid&i_ready with no completion -> o_valid=0 next cycle. o_data holds its value.
- Latency: o_valid rises 1 clk after the ce_ovr at the mid-sample of the last stop bit.
- Framing: a frame with a bad stop is still delivered, with o_frame_err=1. A break (line held 0) yields data 0 with frame_err=1. The receiver then waits in IDLE until rx_s returns to 1 before arming a new start.
- Reset mid-frame: abort immediately and return to the reset values. No partial byte is delivered.

Optional Feature:
UART_RX_MAJORITY_EN.
- Defined: each bit (start/data/parity/stop) is a 2-of-3 majority of samples at phases MID-2, MID-1 and MID. The decision is taken at MID. Timing shifts by one tick; o_valid latency stays measured from the last stop decision.
- Undefined: a single sample at MID-1.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg:
  - state_t enum (shared with uart_tx)
  - parity encoding constants PAR_NONE/PAR_EVEN/PAR_ODD
  - parity function
- One natural sub-module, uart_baud_gen: divider/NCO producing ce_ovr, reused by uart_tx.

Test Plan:
- 0xA5, 8N1 at default rates, i_ready=1 -> o_data=0xA5, o_valid pulse 1 clk, no error flags.
- PARITY=1: send 0x07 with correct parity bit 1 -> parity_err=0. Same data with parity bit 0 -> o_data=0x07, parity_err=1.
- Stop bit forced 0 after 0x3C -> o_data=0x3C, frame_err=1. Line held low 20 bit-times -> data 0x00, frame_err=1, and no new frame until the line returns high.
- i_ready=0: send 0x11 then 0x22 -> o_data stays 0x11, one o_overrun pulse. Raise i_ready on the exact completion cycle of 0x22 -> 0x22 loaded, no overrun.
- Start glitch of 3 ticks low -> no o_valid, o_busy returns to 0. Reset asserted during DATA of 0x55 -> outputs return to reset values; a subsequent 0x81 is received correctly.
- USE_NCO=1, STOP_BITS=2, back-to-back 0x00/0xFF/0x5A -> all three delivered in order with no errors.
